// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI write sequencer.
package spi_pkg;

  localparam int unsigned CMD_WR_BIT = 7;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } state_e;

endpackage

// File: rtl/spi_wr_sequencer_if.sv
// Byte-stream input and register-bank write port of the SPI write sequencer.
interface spi_wr_sequencer_if;
   import spi_pkg::*;

   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              frame_end;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [BYTE_W-1:0] wr_data;

   // master: the sequencer, which consumes bytes and drives the write port
   modport master (
      input  rx_data, rx_valid, frame_end,
      output wr_en, wr_addr, wr_data
   );

   modport slave (
      output rx_data, rx_valid, frame_end,
      input  wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/spi_wr_sequencer.sv
// Parses SPI frames (command byte + data burst) into register-bank writes with
// address auto-increment, burst limiting, frame counting and sticky error flags.
module spi_wr_sequencer
   import spi_pkg::*;
#(
   parameter int unsigned NREG      = 16,
   parameter int unsigned MAX_BURST = 32
) (
   input  logic                clk,
   input  logic                rst,
   spi_wr_sequencer_if.master  bus,
   input  logic                err_clr,
   output logic                busy,
   output logic [15:0]         frame_cnt,
   output logic                err_cmd,
   output logic                err_ovf
);

   localparam logic [ADDR_W:0]   NREG_B    = (ADDR_W+1)'(NREG);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NREG - 1);
   localparam logic [7:0]        MAX_B     = 8'(MAX_BURST);

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        burst_cnt_q;
   logic              wrote_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [BYTE_W-1:0] wr_data_q;
   logic [15:0]       frame_cnt_q;
   logic              err_cmd_q;
   logic              err_ovf_q;

   logic              cmd_ok;
   logic              do_write;
   logic              do_ovf;
   logic [ADDR_W-1:0] addr_next;

   assign cmd_ok    = bus.rx_data[CMD_WR_BIT] &&
                      ({1'b0, bus.rx_data[ADDR_W-1:0]} < NREG_B);
   assign do_write  = (state_q == ST_DATA) && bus.rx_valid && (burst_cnt_q < MAX_B);
   assign do_ovf    = (state_q == ST_DATA) && bus.rx_valid && (burst_cnt_q >= MAX_B);
   assign addr_next = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         burst_cnt_q <= '0;
         wrote_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_cnt_q <= '0;
         err_cmd_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         // Clear first so a set in the same cycle takes priority
         if (err_clr) begin
            err_cmd_q <= 1'b0;
            err_ovf_q <= 1'b0;
         end

         unique case (state_q)
            ST_IDLE: begin
               // A command byte coinciding with frame_end is discarded silently
               if (bus.rx_valid && !bus.frame_end) begin
                  if (cmd_ok) begin
                     state_q     <= ST_DATA;
                     addr_q      <= bus.rx_data[ADDR_W-1:0];
                     burst_cnt_q <= '0;
                     wrote_q     <= 1'b0;
                  end else begin
                     state_q   <= ST_DROP;
                     err_cmd_q <= 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (do_write) begin
                  wr_en_q     <= 1'b1;
                  wr_addr_q   <= addr_q;
                  wr_data_q   <= bus.rx_data;
                  addr_q      <= addr_next;
                  burst_cnt_q <= burst_cnt_q + 8'd1;
                  wrote_q     <= 1'b1;
               end else if (do_ovf) begin
                  state_q   <= ST_DROP;
                  err_ovf_q <= 1'b1;
               end
            end
            ST_DROP: begin
            end
            default: state_q <= ST_IDLE;
         endcase

         if (bus.frame_end) begin
            state_q <= ST_IDLE;
            if ((state_q == ST_DATA) && (wrote_q || do_write)) begin
               frame_cnt_q <= frame_cnt_q + 16'd1;
            end
         end
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign busy        = (state_q != ST_IDLE);
   assign frame_cnt   = frame_cnt_q;
   assign err_cmd     = err_cmd_q;
   assign err_ovf     = err_ovf_q;

endmodule
